// File: rtl/bus_dev_fifo.sv
// Purpose : per-device TX/RX packet FIFO front-end between a device and one bus arbiter port.
// Latency : 1 cycle from write to visibility on D_pop / rx_dout (show-ahead heads).
// Backpress: writes to a full FIFO are dropped and flagged (sticky ovf); a pop on a full FIFO frees room for a same-cycle write.
//
// Optional feature: define BUS_DEV_RX_FILTER_EN to accept only RX packets addressed to `id` or `broadcast`.
// Ports:
//   clk, reset (async active-low)
//   host_wr/host_din        -> TX FIFO write;  tx_full, tx_count  TX status
//   pndng/D_pop/pop         -> TX head request, head data, consume
//   push/D_push             -> RX FIFO write from the bus
//   rx_rd/rx_dout           -> RX head consume / head data; rx_empty, rx_count RX status
//   ovf                     -> sticky lost-write flag (TX or RX)
//   drop_cnt                -> saturating count of rejected or overflowed RX packets
module bus_dev_fifo #(
  parameter int         pckg_sz   = 16,
  parameter int         depth     = 8,
  parameter logic [7:0] id        = 8'd0,
  parameter logic [7:0] broadcast = 8'hFF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       host_wr,
  input  logic [pckg_sz-1:0]         host_din,
  output logic                       tx_full,
  output logic [$clog2(depth+1)-1:0] tx_count,
  output logic                       pndng,
  output logic [pckg_sz-1:0]         D_pop,
  input  logic                       pop,
  input  logic                       push,
  input  logic [pckg_sz-1:0]         D_push,
  input  logic                       rx_rd,
  output logic [pckg_sz-1:0]         rx_dout,
  output logic                       rx_empty,
  output logic [$clog2(depth+1)-1:0] rx_count,
  output logic                       ovf,
  output logic [7:0]                 drop_cnt
);

  localparam int ptr_w = $clog2(depth);
  localparam int cnt_w = $clog2(depth+1);
  localparam logic [cnt_w-1:0] full_val = cnt_w'(depth);

  logic [pckg_sz-1:0] tx_mem [depth];
  logic [pckg_sz-1:0] rx_mem [depth];
  logic [ptr_w-1:0]   tx_rptr, tx_wptr, rx_rptr, rx_wptr;

  logic tx_wr, tx_rd, tx_lost;
  logic rx_full, rx_ok, rx_acc, rx_wr, rx_pop, rx_lost, rx_drop;
  logic [7:0] dest;

  assign dest = D_push[pckg_sz-1 -: 8];

`ifdef BUS_DEV_RX_FILTER_EN
  assign rx_ok = (dest == id) || (dest == broadcast);
`else
  // Without filtering every packet is accepted; the ID parameters are not needed.
  logic unused_filter;
  assign unused_filter = (dest == id) || (dest == broadcast);
  assign rx_ok = 1'b1;
`endif

  // Status is derived from the registered counts only.
  assign tx_full  = (tx_count == full_val);
  assign pndng    = (tx_count != '0);
  assign rx_full  = (rx_count == full_val);
  assign rx_empty = (rx_count == '0);

  // A pop on a full TX frees the slot the write lands in (wptr == rptr when full).
  assign tx_wr   = host_wr && (!tx_full || pop);
  assign tx_rd   = pop && pndng;
  assign tx_lost = host_wr && tx_full && !pop;

  assign rx_acc  = push && rx_ok;
  assign rx_wr   = rx_acc && (!rx_full || rx_rd);
  assign rx_pop  = rx_rd && !rx_empty;
  assign rx_lost = rx_acc && rx_full && !rx_rd;
  assign rx_drop = (push && !rx_ok) || rx_lost;

  // Heads read as zero while empty so the outputs are defined out of reset.
  assign D_pop   = pndng    ? tx_mem[tx_rptr] : '0;
  assign rx_dout = !rx_empty ? rx_mem[rx_rptr] : '0;

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (tx_wr) tx_mem[tx_wptr] <= host_din;
    if (rx_wr) rx_mem[rx_wptr] <= D_push;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_rptr  <= '0;
      tx_wptr  <= '0;
      tx_count <= '0;
      rx_rptr  <= '0;
      rx_wptr  <= '0;
      rx_count <= '0;
      ovf      <= 1'b0;
      drop_cnt <= 8'd0;
    end else begin
      if (tx_wr) tx_wptr <= tx_wptr + 1'b1;
      if (tx_rd) tx_rptr <= tx_rptr + 1'b1;
      case ({tx_wr, tx_rd})
        2'b10:   tx_count <= tx_count + 1'b1;
        2'b01:   tx_count <= tx_count - 1'b1;
        default: tx_count <= tx_count;
      endcase

      if (rx_wr)  rx_wptr <= rx_wptr + 1'b1;
      if (rx_pop) rx_rptr <= rx_rptr + 1'b1;
      case ({rx_wr, rx_pop})
        2'b10:   rx_count <= rx_count + 1'b1;
        2'b01:   rx_count <= rx_count - 1'b1;
        default: rx_count <= rx_count;
      endcase

      if (tx_lost || rx_lost) ovf <= 1'b1;
      if (rx_drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_bus_dev_fifo.sv
// Purpose : randomized and directed bench for bus_dev_fifo against a queue-based reference model.
// Latency : model applies each cycle's inputs at the rising edge; outputs compared on the falling edge.
// Backpress: model drops full-FIFO writes and counts RX drops exactly as the device contract describes.
module tb_bus_dev_fifo;

  localparam int PSZ = 16;
  localparam int DEP = 8;
  localparam logic [7:0] MY_ID = 8'h03;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        host_wr = 1'b0;
  logic [15:0] host_din = '0;
  logic        tx_full;
  logic [3:0]  tx_count;
  logic        pndng;
  logic [15:0] D_pop;
  logic        pop = 1'b0;
  logic        push = 1'b0;
  logic [15:0] D_push = '0;
  logic        rx_rd = 1'b0;
  logic [15:0] rx_dout;
  logic        rx_empty;
  logic [3:0]  rx_count;
  logic        ovf;
  logic [7:0]  drop_cnt;

  bus_dev_fifo #(.pckg_sz(PSZ), .depth(DEP), .id(MY_ID), .broadcast(8'hFF)) dut (
    .clk(clk), .reset(reset),
    .host_wr(host_wr), .host_din(host_din), .tx_full(tx_full), .tx_count(tx_count),
    .pndng(pndng), .D_pop(D_pop), .pop(pop),
    .push(push), .D_push(D_push), .rx_rd(rx_rd), .rx_dout(rx_dout),
    .rx_empty(rx_empty), .rx_count(rx_count), .ovf(ovf), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model state
  logic [15:0] txq[$];
  logic [15:0] rxq[$];
  bit          m_ovf;
  int          m_drop;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic bit accepts(input logic [15:0] pkt);
`ifdef BUS_DEV_RX_FILTER_EN
    return (pkt[15:8] == MY_ID) || (pkt[15:8] == 8'hFF);
`else
    return (pkt[15:8] == pkt[15:8]);
`endif
  endfunction

  task automatic model_clear();
    txq.delete();
    rxq.delete();
    m_ovf  = 1'b0;
    m_drop = 0;
  endtask

  task automatic check_all();
    chk("tx_full",  {31'd0, tx_full},  {31'd0, (txq.size() == DEP)});
    chk("tx_count", {28'd0, tx_count}, txq.size());
    chk("pndng",    {31'd0, pndng},    {31'd0, (txq.size() != 0)});
    chk("D_pop",    {16'd0, D_pop},    {16'd0, (txq.size() != 0) ? txq[0] : 16'h0});
    chk("rx_empty", {31'd0, rx_empty}, {31'd0, (rxq.size() == 0)});
    chk("rx_count", {28'd0, rx_count}, rxq.size());
    chk("rx_dout",  {16'd0, rx_dout},  {16'd0, (rxq.size() != 0) ? rxq[0] : 16'h0});
    chk("ovf",      {31'd0, ovf},      {31'd0, m_ovf});
    chk("drop_cnt", {24'd0, drop_cnt}, m_drop);
  endtask

  // One clock of stimulus, called from the falling edge; checks on the next falling edge.
  task automatic cyc(input bit hw, input logic [15:0] hd, input bit pp,
                     input bit ps, input logic [15:0] dp, input bit rr, input bit do_chk);
    bit tfull, rfull;
    host_wr = hw; host_din = hd; pop = pp; push = ps; D_push = dp; rx_rd = rr;
    @(posedge clk);
    tfull = (txq.size() == DEP);
    if (pp && txq.size() != 0) void'(txq.pop_front());
    if (hw) begin
      if (!tfull || pp) txq.push_back(hd);
      else m_ovf = 1'b1;
    end
    rfull = (rxq.size() == DEP);
    if (rr && rxq.size() != 0) void'(rxq.pop_front());
    if (ps) begin
      if (!accepts(dp)) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
      else if (rfull && !rr) begin
        m_ovf  = 1'b1;
        m_drop = (m_drop < 255) ? m_drop + 1 : 255;
      end else rxq.push_back(dp);
    end
    @(negedge clk);
    host_wr = 1'b0; pop = 1'b0; push = 1'b0; rx_rd = 1'b0;
    if (do_chk) check_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    @(negedge clk);
    check_all();
    reset = 1'b1;
  endtask

  function automatic logic [15:0] rnd_pkt();
    logic [7:0] d;
    case ($urandom_range(0, 3))
      0: d = MY_ID;
      1: d = 8'hFF;
      2: d = 8'h05;
      default: d = 8'($urandom);
    endcase
    return {d, 8'($urandom)};
  endfunction

  initial begin
    model_clear();
    #12;
    check_all();                         // reset state
    chk("rst_rx_empty", {31'd0, rx_empty}, 32'd1);
    do_reset();

    // Fill TX with 0100..0107, then drain in order.
    for (int i = 0; i < 8; i++) cyc(1, 16'h0100 + 16'(i), 0, 0, 0, 0, 1);
    chk("fill_full",  {31'd0, tx_full}, 32'd1);
    chk("fill_count", {28'd0, tx_count}, 32'd8);
    chk("fill_head",  {16'd0, D_pop}, 32'h0100);
    for (int i = 0; i < 8; i++) begin
      chk("drain_order", {16'd0, D_pop}, 32'h0100 + i);
      cyc(0, 0, 1, 0, 0, 0, 1);
    end
    chk("drain_pndng", {31'd0, pndng}, 32'd0);
    chk("drain_ovf",   {31'd0, ovf}, 32'd0);

    // Overflow on full TX, then simultaneous write+pop at full.
    for (int i = 0; i < 8; i++) cyc(1, 16'h0200 + 16'(i), 0, 0, 0, 0, 1);
    cyc(1, 16'h0999, 0, 0, 0, 0, 1);
    chk("ovf_set",  {31'd0, ovf}, 32'd1);
    chk("ovf_head", {16'd0, D_pop}, 32'h0200);
    cyc(1, 16'h0AAA, 1, 0, 0, 0, 1);
    chk("wrpop_count", {28'd0, tx_count}, 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) chk("last_out", {16'd0, D_pop}, 32'h0AAA);
      cyc(0, 0, 1, 0, 0, 0, 1);
    end

    // Simultaneous write+pop on empty TX: the pop is ignored.
    cyc(1, 16'h0BBB, 1, 0, 0, 0, 1);
    chk("wrpop_empty", {28'd0, tx_count}, 32'd1);

    // RX filter.
    do_reset();
    cyc(0, 0, 0, 1, 16'h0311, 0, 1);
    cyc(0, 0, 0, 1, 16'hFF22, 0, 1);
    cyc(0, 0, 0, 1, 16'h0533, 0, 1);
`ifdef BUS_DEV_RX_FILTER_EN
    chk("filt_rx_count", {28'd0, rx_count}, 32'd2);
    chk("filt_drop",     {24'd0, drop_cnt}, 32'd1);
`else
    chk("filt_rx_count", {28'd0, rx_count}, 32'd3);
    chk("filt_drop",     {24'd0, drop_cnt}, 32'd0);
`endif

    // 20 interleaved write/pop cycles across pointer wrap.
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1, 16'($urandom), 0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++)
      cyc(1'($urandom), 16'($urandom), 1'($urandom), 0, 0, 0, 1);

    // RX overflow and drop_cnt saturation.
    do_reset();
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1, {MY_ID, 8'(i)}, 0, 1);
    for (int i = 0; i < 300; i++) cyc(0, 0, 0, 1, {MY_ID, 8'(i)}, 0, 0);
    check_all();
    chk("sat_drop", {24'd0, drop_cnt}, 32'hFF);
    chk("sat_ovf",  {31'd0, ovf}, 32'd1);

    // Asynchronous reset mid-cycle with both FIFOs half full.
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, 16'h0C00 + 16'(i), 0, 1, {MY_ID, 8'(i)}, 0, 1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    model_clear();
    check_all();
    chk("async_pndng", {31'd0, pndng}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Random traffic on both sides.
    for (int i = 0; i < 600; i++)
      cyc(1'($urandom_range(0, 2) != 0), 16'($urandom), 1'($urandom),
          1'($urandom_range(0, 2) != 0), rnd_pkt(), 1'($urandom), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bus_dev_fifo.md
# bus_dev_fifo

Per-device FIFO front-end between one device and one port of the `bs_gnrtr_n_rbtr` bus generator/arbiter. The transmit side buffers host packets and presents them to the bus through the `pndng`/`D_pop`/`pop` handshake. The receive side captures packets the bus delivers with `push`/`D_push`. One instance exists per bus device, `drvrs` instances in total.

## Interface
- `pckg_sz`, 16: packet width in bits. Bits `[pckg_sz-1:pckg_sz-8]` carry the destination ID.
- `depth`, 8: entries per FIFO, power of two, ≥2.
- `id`, 0: this device's 8-bit ID.
- `broadcast`, 8'hFF: destination ID that addresses all devices.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `host_wr`  in  1  host writes `host_din` into the TX FIFO.
- `host_din`  in  pckg_sz  packet from the host.
- `tx_full`  out  1  TX FIFO holds `depth` entries.
- `tx_count`  out  $clog2(depth+1)  TX occupancy.
- `pndng`  out  1  TX FIFO non-empty; request to the arbiter.
- `D_pop`  out  pckg_sz  TX head entry (show-ahead).
- `pop`  in  1  arbiter consumes the TX head.
- `push`  in  1  bus delivers `D_push` to this device.
- `D_push`  in  pckg_sz  packet from the bus.
- `rx_rd`  in  1  host reads the RX head.
- `rx_dout`  out  pckg_sz  RX head entry (show-ahead).
- `rx_empty`  out  1  RX FIFO empty.
- `rx_count`  out  $clog2(depth+1)  RX occupancy.
- `ovf`  out  1  sticky: a write was lost to a full FIFO (TX or RX).
- `drop_cnt`  out  8  saturating count of RX packets rejected by the filter or lost to overflow.

## Operation
- Two independent circular FIFOs, TX and RX. Each has a read pointer, a write pointer (both `$clog2(depth)` bits, natural wrap), and an occupancy counter.
- **TX write:** `host_wr` with `!tx_full` stores `host_din` and increments `tx_count`.
  - `host_wr` with `tx_full` and no `pop` in the same cycle: data is discarded, `ovf` is set, and storage is unchanged.
- **TX read:** `pop` with `pndng` advances the read pointer and decrements `tx_count`.
  - `pop` while empty is ignored: no pointer change, no flag.
- **TX simultaneous write and pop:**
  - When full, the write is accepted and the count stays at `depth`.
  - When empty, the pop is ignored and the write is accepted.
- **RX write:** `push` with `D_push` accepted stores the packet (acceptance is defined under Configuration).
  - A rejected packet increments `drop_cnt`.
  - RX full with no same-cycle `rx_rd`: the packet is dropped, `ovf` is set and `drop_cnt` is incremented.
- **RX read:** `rx_rd` with `!rx_empty` pops the RX head. `rx_rd` while empty is ignored.
- `drop_cnt` saturates at 8'hFF.
- `ovf` clears only on reset.
- Control is counter/pointer based. Each FIFO has implicit states EMPTY, PARTIAL and FULL, selected by its count:
  - `count==0` is EMPTY.
  - `count==depth` is FULL.
  - Anything else is PARTIAL.

## Timing
- Reset (`reset`=0, asynchronous) drives:
  - pointers and counts to 0;
  - `pndng`=0, `tx_full`=0, `rx_empty`=1, `ovf`=0, `drop_cnt`=0;
  - `D_pop` and `rx_dout` to 0.
  - Storage contents are not reset.
- Reset asserted mid-transfer flushes both FIFOs immediately. Release of reset is sampled synchronously at the next edge.
- Write-to-visibility latency is 1 cycle. A packet written at edge N appears on `D_pop` with `pndng`=1 (or on `rx_dout` with `rx_empty`=0) after edge N.
- `D_pop` and `rx_dout` are driven combinationally from registered storage at the read pointer. Their value is stable for the whole cycle.
- `pop` in cycle N: the next entry appears on `D_pop` after edge N. `pndng` drops after edge N if the popped entry was the last.
- All status outputs are derived from registered counts. There is no combinational path from any input to any output.

## Configuration
- `BUS_DEV_RX_FILTER_EN` defined:
  - RX accepts only packets whose destination field equals `id` or `broadcast`.
  - A packet with any other destination is rejected and counted in `drop_cnt`.
- Not defined:
  - Every `push` is accepted (subject only to RX full).
  - `drop_cnt` counts only overflow drops.

## Test plan
- Reset, then 8 `host_wr` of 16'h0100..16'h0107 (depth 8) → `tx_full`=1, `tx_count`=8, `D_pop`=16'h0100. Continue with 8 `pop` → 16'h0100..16'h0107 in order, then `pndng`=0, `ovf`=0.
- On a full TX, a 9th `host_wr` without `pop` → `ovf`=1 and contents unchanged. Then `host_wr`+`pop` together on a full TX → count stays 8 and the new packet is last out.
- 20 interleaved write/pop cycles across pointer wrap → output order matches input order exactly.
- With `BUS_DEV_RX_FILTER_EN` and `id`=3, `push` the destinations 8'h03, 8'hFF and 8'h05 → `rx_count`=2, `drop_cnt`=1. Without the macro, the same stimulus gives `rx_count`=3, `drop_cnt`=0.
- Fill RX (8 entries), then 300 further `push` → `drop_cnt`=8'hFF (saturated) and `ovf`=1.
- Drive `reset`=0 asynchronously mid-cycle with both FIFOs half full → all outputs at their reset values before the next `clk` edge.
